// File: rtl/branch_info_queue.sv
// In-order {pc, counter} queue from predict to commit; pop-to-commit strobe is 1 cycle; pred_ready drops when full.
// A push to a full queue or a resolve on an empty queue is ignored. Optional stats: BRANCH_INFO_QUEUE_STATS_EN.
module branch_info_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 5,
  parameter int CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     pred_valid,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic [CNT_W-1:0]         pred_counter,
  output logic                     pred_ready,
  output logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic [PC_W-1:0]          commit_pc,
  output logic                     commit_taken,
  output logic [CNT_W-1:0]         commit_counter,
  output logic                     commit_update,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count
`ifdef BRANCH_INFO_QUEUE_STATS_EN
  ,
  output logic [31:0]              stat_commits,
  output logic [31:0]              stat_mispredicts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] counter;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  entry_t        headEnt;
  logic          pushAcc;
  logic          popAcc;
  logic          headMiss;

  assign pred_ready = (count < DEPTH_C);
  assign pred_taken = pred_counter[CNT_W-1];
  assign pushAcc    = pred_valid && pred_ready;
  assign popAcc     = resolve_valid && (count != '0);
  assign headEnt    = mem[head];
  assign headMiss   = (resolve_taken != headEnt.counter[CNT_W-1]);

  // Entry storage carries no reset; contents are only read behind a nonzero count.
  always_ff @(posedge clk) begin
    if (pushAcc && !flush) begin
      mem[tail] <= entry_t'{pc: pred_pc, counter: pred_counter};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pushAcc) tail <= tail + AW'(1);
      if (popAcc)  head <= head + AW'(1);
      count <= count + CW'(pushAcc) - CW'(popAcc);
    end
  end

  // Commit side follows the pop regardless of a same-cycle flush.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      commit_pc      <= '0;
      commit_taken   <= 1'b0;
      commit_counter <= CNT_W'(1);
      commit_update  <= 1'b0;
      mispredict     <= 1'b0;
    end else begin
      commit_update <= popAcc;
      mispredict    <= popAcc && headMiss;
      if (popAcc) begin
        commit_pc      <= headEnt.pc;
        commit_counter <= headEnt.counter;
        commit_taken   <= resolve_taken;
      end
    end
  end

`ifdef BRANCH_INFO_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_commits     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (popAcc && (stat_commits != '1)) stat_commits <= stat_commits + 32'd1;
      if (popAcc && headMiss && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
